// File: rtl/nms_pkg.sv
// Shared types and constants for the NMS stream controller slice.
package nms_pkg;

  localparam int CFG_W     = 11;
  localparam int WIN_CNT_W = 22;
  localparam int MIN_DIM   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/nms_frame_counter.sv
// Column/row position of the incoming pixel stream with line-end and
// frame-end detection for the current handshake.
module nms_frame_counter
  import nms_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [CFG_W-1:0] iw,
  input  logic [CFG_W-1:0] ih,
  output logic             line_end,
  output logic             frame_end
);

  logic [CFG_W-1:0] col_r;
  logic [CFG_W-1:0] row_r;

  assign line_end  = adv && (col_r == (iw - 11'd1));
  assign frame_end = line_end && (row_r == (ih - 11'd1));

  // Column advances per pixel and wraps at the line end, bumping the row.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col_r <= 11'd0;
      row_r <= 11'd0;
    end else if (line_end) begin
      col_r <= 11'd0;
      row_r <= row_r + 11'd1;
    end else if (adv) begin
      col_r <= col_r + 11'd1;
    end else begin
      col_r <= col_r;
    end
  end

endmodule

// File: rtl/nms_stream_ctrl.sv
// Frame sequencer feeding the NMS 3x3 window buffer.
// Optional statistics counters are enabled with `define NMS_CTRL_STATS_EN.
module nms_stream_ctrl
  import nms_pkg::*;
#(
  parameter int DATAWID       = 8,
  parameter int MAX_W         = 2047,
  parameter int LINE_GAP      = 2,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [10:0]        cfg_iw,
  input  logic [10:0]        cfg_ih,
  input  logic               s_valid,
  input  logic [DATAWID-1:0] s_data,
  output logic               s_ready,
  output logic               buf_din_valid,
  output logic [DATAWID-1:0] buf_din,
  output logic [10:0]        buf_iw,
  output logic [10:0]        buf_ih,
  input  logic               buf_dout_valid,
  output logic               busy,
  output logic               done,
  output logic               err_cfg,
  output logic               err_timeout,
  output logic [15:0]        frame_cnt,
  output logic [23:0]        stall_cnt
);

  localparam int DR_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

  state_t state_r, state_next_s;
  logic s_ready_r, busy_r, done_r, err_cfg_r, err_timeout_r, buf_din_valid_r;
  logic [DATAWID-1:0]   buf_din_r;
  logic [CFG_W-1:0]     iw_r, ih_r;
  logic [WIN_CNT_W-1:0] win_cnt_r, win_exp_r, win_cnt_next_s, iw_m2_s, ih_m2_s;
  logic [DR_W-1:0]      drain_cnt_r;
  logic [GAP_W-1:0]     gap_cnt_r;
  logic hs_s, cfg_ok_s, accept_s, reject_s, timeout_s, line_end_s, frame_end_s;

  assign hs_s     = s_valid && s_ready_r;
  assign cfg_ok_s = (cfg_iw >= CFG_W'(MIN_DIM)) && (cfg_iw <= CFG_W'(MAX_W)) &&
                    (cfg_ih >= CFG_W'(MIN_DIM));
  assign iw_m2_s  = {11'd0, cfg_iw} - 22'd2;
  assign ih_m2_s  = {11'd0, cfg_ih} - 22'd2;
  assign win_cnt_next_s = buf_dout_valid ? (win_cnt_r + 22'd1) : win_cnt_r;

  nms_frame_counter u_frame_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept_s),
    .adv       (hs_s),
    .iw        (iw_r),
    .ih        (ih_r),
    .line_end  (line_end_s),
    .frame_end (frame_end_s)
  );

  // Next-state decode; the window count beats the drain timeout on a tie.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && cfg_ok_s) begin
          accept_s     = 1'b1;
          state_next_s = ST_RUN;
        end else if (start) begin
          reject_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (frame_end_s) begin
          state_next_s = ST_DRAIN;
        end else if (line_end_s && (LINE_GAP > 0)) begin
          state_next_s = ST_GAP;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_W'(LINE_GAP - 1)) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_GAP;
        end
      end
      ST_DRAIN: begin
        if (win_cnt_next_s >= win_exp_r) begin
          state_next_s = ST_DONE;
        end else if (drain_cnt_r == DR_W'(DRAIN_TIMEOUT - 1)) begin
          timeout_s    = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State and status outputs, registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      s_ready_r       <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      err_cfg_r       <= 1'b0;
      err_timeout_r   <= 1'b0;
      buf_din_valid_r <= 1'b0;
      buf_din_r       <= '0;
    end else begin
      state_r         <= state_next_s;
      s_ready_r       <= (state_next_s == ST_RUN);
      busy_r          <= (state_next_s != ST_IDLE);
      done_r          <= (state_next_s == ST_DONE);
      err_cfg_r       <= reject_s;
      buf_din_valid_r <= hs_s;
      buf_din_r       <= hs_s ? s_data : buf_din_r;
      err_timeout_r   <= accept_s ? 1'b0 : (timeout_s ? 1'b1 : err_timeout_r);
    end
  end

  // Frame config latch, window tally and gap/drain cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      iw_r        <= 11'd0;
      ih_r        <= 11'd0;
      win_exp_r   <= 22'd0;
      win_cnt_r   <= 22'd0;
      gap_cnt_r   <= '0;
      drain_cnt_r <= '0;
    end else begin
      if (accept_s) begin
        iw_r      <= cfg_iw;
        ih_r      <= cfg_ih;
        win_exp_r <= iw_m2_s * ih_m2_s;
        win_cnt_r <= 22'd0;
      end else if (state_r != ST_IDLE) begin
        win_cnt_r <= win_cnt_next_s;
      end else begin
        win_cnt_r <= win_cnt_r;
      end
      gap_cnt_r   <= (state_r == ST_GAP) ? (gap_cnt_r + GAP_W'(1)) : '0;
      drain_cnt_r <= (state_r == ST_DRAIN) ? (drain_cnt_r + DR_W'(1)) : '0;
    end
  end

  assign s_ready       = s_ready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err_cfg       = err_cfg_r;
  assign err_timeout   = err_timeout_r;
  assign buf_din_valid = buf_din_valid_r;
  assign buf_din       = buf_din_r;
  assign buf_iw        = iw_r;
  assign buf_ih        = ih_r;

`ifdef NMS_CTRL_STATS_EN
  logic [15:0] frame_cnt_r;
  logic [23:0] stall_cnt_r;

  // Completed-frame counter (wrapping) and per-frame gap stall counter (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 16'd0;
      stall_cnt_r <= 24'd0;
    end else begin
      frame_cnt_r <= (state_next_s == ST_DONE) ? (frame_cnt_r + 16'd1) : frame_cnt_r;
      if (accept_s) begin
        stall_cnt_r <= 24'd0;
      end else if ((state_r == ST_GAP) && (stall_cnt_r != 24'hFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 24'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign stall_cnt = stall_cnt_r;
`else
  assign frame_cnt = 16'd0;
  assign stall_cnt = 24'd0;
`endif

endmodule

// File: doc/nms_stream_ctrl.md
# nms_stream_ctrl

Frame-level controller that sequences the pixel stream into the NMS 3x3 window buffer. It latches the per-frame image size on a start pulse and applies upstream backpressure, including a fixed inter-line gap that lets the buffer's line FIFOs settle. It feeds the buffer one pixel per handshake, then counts the buffer's output windows to detect frame completion and raise `done`. It sits between the Sobel/direction stage output and the NMS window buffer.

## Interface
Parameters:
- `DATAWID`, default 8: pixel width.
- `MAX_W`, default 2047: largest legal `cfg_iw`.
- `LINE_GAP`, default 2: `s_ready`-low cycles inserted after each non-final line.
- `DRAIN_TIMEOUT`, default 4096: maximum cycles spent waiting for windows after the last pixel.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high. Clock is `clk`.
- `start` in 1: one-cycle pulse that begins a frame.
- `cfg_iw` in 11: frame width, sampled on accepted `start`.
- `cfg_ih` in 11: frame height, sampled on accepted `start`.
- `s_valid` in 1: upstream pixel valid.
- `s_data` in DATAWID: upstream pixel.
- `s_ready` out 1: upstream ready.
- `buf_din_valid` out 1: to window buffer `din_valid`.
- `buf_din` out DATAWID: to window buffer `din`.
- `buf_iw` out 11: latched width, to buffer `IW`.
- `buf_ih` out 11: latched height, to buffer `IH`.
- `buf_dout_valid` in 1: window buffer `dout_valid`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle frame-complete pulse.
- `err_cfg` out 1: one-cycle pulse when `start` is rejected.
- `err_timeout` out 1: sticky drain-timeout flag; cleared by the next accepted `start`.
- `frame_cnt` out 16: completed frames (see Configuration).
- `stall_cnt` out 24: LINE_GAP stall cycles in the current frame (see Configuration).

## Operation
States: IDLE, RUN, GAP, DRAIN, DONE.

IDLE:
- `s_ready`=0.
- On `start`, config is legal when 3 ≤ `cfg_iw` ≤ `MAX_W` and `cfg_ih` ≥ 3.
- Legal: latch config into `buf_iw`/`buf_ih`, clear col/row/window counters and `err_timeout`, go to RUN.
- Illegal: pulse `err_cfg`, remain in IDLE.

RUN:
- `s_ready`=1.
- Handshake is `s_valid && s_ready`. Each handshake increments col; `buf_din`/`buf_din_valid` register the pixel.
- At col = IW-1 on a handshake, col wraps to 0 and row increments.
- If that was the last line (row = IH-1), go to DRAIN; otherwise go to GAP.

GAP:
- `s_ready`=0 for exactly `LINE_GAP` cycles, then return to RUN.
- `LINE_GAP`=0 skips GAP entirely.

DRAIN:
- `s_ready`=0. Each `buf_dout_valid` increments the 22-bit window counter.
- Expected window count is (IW-2)*(IH-2), computed at start in 22 bits.
- Count reached: go to DONE.
- Drain cycle counter reaches `DRAIN_TIMEOUT`: set `err_timeout`, go to DONE.
- If both happen in the same cycle, the count wins and `err_timeout` stays 0.

DONE:
- `done`=1 for one cycle, then go to IDLE.

Other rules:
- `start` outside IDLE is ignored; no error.
- `buf_dout_valid` outside DRAIN still counts toward the window total, because windows appear while the frame is still streaming.
- `rst` mid-frame returns to IDLE with every output at its reset value. The downstream window buffer must share the same `rst`.

## Timing
- Reset values: all outputs 0, including `buf_iw`/`buf_ih`.
- `s_ready` is a function of registered state only; there is no combinational path from `s_valid`.
- `buf_din_valid`/`buf_din` follow the handshake by 1 cycle.
- `buf_iw`/`buf_ih` are valid from the cycle after the accepted `start`.
- `done` asserts 1 cycle after the final window is counted. `err_timeout` rises in the same cycle `done` asserts.
- Back-to-back frames: the earliest next `start` is the cycle after `done`.
- Minimum frame duration: IW*IH + (IH-1)*LINE_GAP + 1 cycles plus drain.

## Configuration
`NMS_CTRL_STATS_EN`:
- Defined: `frame_cnt` increments on each `done` and wraps at 2^16. `stall_cnt` counts GAP cycles, clears on accepted `start`, and saturates at 2^24-1.
- Undefined: both ports are tied to 0 and their counters are not synthesized.

## Structure
- Shared package `nms_pkg`: state enum, `CFG_W`=11, `WIN_CNT_W`=22, and the `MIN_DIM`=3 constant.
- One sub-module, `nms_frame_counter`, holds the col/row counters with wrap and last-pixel detection. Everything else lives in the top module.

## Test plan
1. Legal 5x4 frame, continuous `s_valid`, `LINE_GAP`=2, model buffer → 20 `buf_din_valid` pulses, 3 gaps of 2 cycles, 6 windows counted, one `done`, `err_timeout`=0.
2. `start` with `cfg_iw`=2 → `err_cfg` pulses once; stays in IDLE with `s_ready`=0 and `busy`=0.
3. Drain with `buf_dout_valid` withheld → `err_timeout`=1 and `done` pulse exactly `DRAIN_TIMEOUT` cycles after DRAIN entry; flag clears on the next `start`.
4. `rst` asserted after 7 pixels of a 5x4 frame → all outputs 0 next cycle; a new `start` completes a frame normally.
5. Random `s_valid` bubbles on an 8x3 frame → exactly 24 forwarded pixels, each arriving 1 cycle after its handshake; `start` during RUN ignored.
6. With `NMS_CTRL_STATS_EN`: two back-to-back 5x4 frames → `frame_cnt`=2; `stall_cnt`=6 after each frame.
